// File: rtl/ecc_gf2m_seq.sv
// Sequencer for GF(2^WIDTH) field operations: chain (mul, add, sqr), mul, sqr and add.
// Uses an internal bit-serial multiplier. Define ECC_GF2M_SEQ_ZERO_CHK_EN to add the zero_flag output.
module ecc_gf2m_seq #(
  parameter int unsigned      WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(128'h87)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             swap,
  input  logic             abort,
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] ry,
  output logic [WIDTH-1:0] xx_out,
  output logic [WIDTH-1:0] zz_out,
  output logic [WIDTH-1:0] bp_out,
  output logic             busy,
  output logic             done
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
  ,
  output logic             zero_flag
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_CHAIN = 2'b00;
  localparam logic [1:0] MODE_MUL   = 2'b01;
  localparam logic [1:0] MODE_SQR   = 2'b10;
  localparam logic [1:0] MODE_ADD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ADD,
    S_SQR,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sqr_src, mul_a, mul_b, acc_next, add_res;
  logic             last;

  // Datapath: one MSB-first shift-and-add step, plus the single-cycle field add.
  always_comb begin
    sqr_src  = (mode_q == MODE_CHAIN) ? zz_out : op_a;
    mul_a    = (state == S_SQR) ? sqr_src : op_a;
    mul_b    = (state == S_SQR) ? sqr_src : op_b;
    acc_next = (acc << 1) ^ (acc[WIDTH-1] ? POLY : '0) ^ (mul_b[cnt] ? mul_a : '0);
    add_res  = ((mode_q == MODE_CHAIN) ? xx_out : op_b) ^ op_a;
    last     = (cnt == '0);
  end

  // Next-state logic; abort wins in every busy state.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (mode)
            MODE_SQR: state_d = S_SQR;
            MODE_ADD: state_d = S_ADD;
            default:  state_d = S_MUL;
          endcase
        end
      end
      S_MUL: begin
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = (mode_q == MODE_CHAIN) ? S_ADD : S_DONE;
      end
      S_ADD: begin
        if (abort) state_d = S_IDLE;
        else       state_d = (mode_q == MODE_CHAIN) ? S_SQR : S_DONE;
      end
      S_SQR: begin
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      mode_q <= MODE_CHAIN;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      cnt    <= '0;
      xx_out <= '0;
      zz_out <= '0;
      bp_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
      zero_flag <= 1'b0;
`endif
    end else begin
      state <= state_d;
      busy  <= (state_d != S_IDLE);
      done  <= (state_d == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            op_a   <= swap ? ry : rx;
            op_b   <= swap ? rx : ry;
            acc    <= '0;
            cnt    <= CNT_TOP;
          end
        end
        S_MUL: begin
          if (!abort) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (last) begin
              xx_out <= acc_next;
              acc    <= '0;
              cnt    <= CNT_TOP;
            end
          end
        end
        S_ADD: begin
          if (!abort) begin
            zz_out <= add_res;
            acc    <= '0;
            cnt    <= CNT_TOP;
          end
        end
        S_SQR: begin
          if (!abort) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (last) bp_out <= acc_next;
          end
        end
        default: ;
      endcase
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
      // Flag tracks the result written on the edge that enters DONE.
      if (state_d == S_DONE && state != S_DONE)
        zero_flag <= ((state == S_ADD) ? add_res : acc_next) == '0;
`endif
    end
  end

endmodule

// File: tb/tb_ecc_gf2m_seq.sv
// Bench for ecc_gf2m_seq: directed and random runs against a polynomial-arithmetic model,
// one 8-bit instance (POLY 0x1B) and one 128-bit instance (POLY 0x87).
module tb_ecc_gf2m_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start8, swap8, abort8, busy8, done8;
  logic [1:0] mode8;
  logic [7:0] rx8, ry8, xx8, zz8, bp8;

  logic         start128, swap128, abort128, busy128, done128;
  logic [1:0]   mode128;
  logic [127:0] rx128, ry128, xx128, zz128, bp128;

`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
  logic zf8, zf128;
`endif

  ecc_gf2m_seq #(.WIDTH(8), .POLY(8'h1B)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .swap(swap8), .abort(abort8),
    .rx(rx8), .ry(ry8), .xx_out(xx8), .zz_out(zz8), .bp_out(bp8), .busy(busy8), .done(done8)
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
    , .zero_flag(zf8)
`endif
  );

  ecc_gf2m_seq #(.WIDTH(128), .POLY(128'h87)) u_dut128 (
    .clk(clk), .rst(rst), .start(start128), .mode(mode128), .swap(swap128), .abort(abort128),
    .rx(rx128), .ry(ry128), .xx_out(xx128), .zz_out(zz128), .bp_out(bp128), .busy(busy128),
    .done(done128)
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
    , .zero_flag(zf128)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] ex_xx8 = '0, ex_zz8 = '0, ex_bp8 = '0;
  logic [127:0] ex_xx128 = '0, ex_zz128 = '0, ex_bp128 = '0;
  logic         ex_zf8 = 1'b0, ex_zf128 = 1'b0;

  // Carry-less product followed by long division by x^w + poly.
  function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b,
                                        input int w, input logic [127:0] poly);
    logic [255:0] p, m;
    p = '0;
    for (int i = 0; i < w; i++)
      if (b[i]) p = p ^ ({128'b0, a} << i);
    m = {128'b0, poly} | (256'b1 << w);
    for (int i = 2 * w - 2; i >= w; i--)
      if (p[i]) p = p ^ (m << (i - w));
    return p[127:0];
  endfunction

  function automatic int lat_of(input logic [1:0] m, input int w);
    case (m)
      2'b00:   return 2 * w + 2;
      2'b11:   return 2;
      default: return w + 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs; abort_c is the busy cycle in which abort is raised (0 = none).
  task automatic model(input logic [1:0] m, input logic s, input logic [127:0] a,
                       input logic [127:0] b, input int w, input logic [127:0] poly,
                       input int abort_c, inout logic [127:0] xx, inout logic [127:0] zz,
                       inout logic [127:0] bp, inout logic zf);
    logic [127:0] oa, ob, p, q, r;
    bit full;
    full = (abort_c == 0);
    oa = s ? b : a;
    ob = s ? a : b;
    case (m)
      2'b00: begin
        p = gmul(oa, ob, w, poly);
        q = p ^ oa;
        r = gmul(q, q, w, poly);
        if (full || abort_c > w)         xx = p;
        if (full || abort_c > w + 1)     zz = q;
        if (full || abort_c > 2 * w + 1) bp = r;
        if (full) zf = (r == '0);
      end
      2'b01: begin
        p = gmul(oa, ob, w, poly);
        if (full || abort_c > w) xx = p;
        if (full) zf = (p == '0);
      end
      2'b10: begin
        r = gmul(oa, oa, w, poly);
        if (full || abort_c > w) bp = r;
        if (full) zf = (r == '0);
      end
      default: begin
        q = oa ^ ob;
        if (full || abort_c > 1) zz = q;
        if (full) zf = (q == '0);
      end
    endcase
  endtask

  task automatic run8(input logic [1:0] m, input logic s, input logic [7:0] a,
                      input logic [7:0] b, input bit hold, input int abort_c, input string tag);
    int lat, cyc, gaps, dones;
    lat = lat_of(m, 8);
    @(negedge clk);
    mode8 = m; swap8 = s; rx8 = a; ry8 = b; start8 = 1'b1;
    abort8 = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start8 = hold; abort8 = 1'b0;
    mode8 = 2'($urandom); swap8 = 1'($urandom); rx8 = 8'($urandom); ry8 = 8'($urandom);
    model(m, s, 128'(a), 128'(b), 8, 128'h1B, abort_c, ex_xx8, ex_zz8, ex_bp8, ex_zf8);
    cyc = 1; gaps = 0; dones = 0;
    if (abort_c != 0) begin
      while (cyc < abort_c) begin
        if (done8) dones++;
        @(posedge clk); #1; cyc++;
      end
      chk({tag, "_busy_pre_abort"}, 128'(busy8), 128'(1));
      abort8 = 1'b1;
      @(posedge clk); #1;
      abort8 = 1'b0; start8 = 1'b0;
      chk({tag, "_busy_post_abort"}, 128'(busy8), 128'(0));
      repeat (3) begin
        if (done8) dones++;
        @(posedge clk); #1;
      end
      chk({tag, "_no_done"}, 128'(dones), 128'(0));
    end else begin
      while (!done8 && cyc <= lat + 4) begin
        if (!busy8) gaps++;
        @(posedge clk); #1; cyc++;
      end
      chk({tag, "_latency"}, 128'(cyc), 128'(lat));
      chk({tag, "_busy_gaps"}, 128'(gaps), 128'(0));
      chk({tag, "_busy_at_done"}, 128'(busy8), 128'(1));
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
      chk({tag, "_zero_flag"}, 128'(zf8), 128'(ex_zf8));
`endif
      start8 = hold;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk({tag, "_done_pulse_end"}, 128'(done8), 128'(0));
      chk({tag, "_idle_after"}, 128'(busy8), 128'(0));
    end
    chk({tag, "_xx"}, 128'(xx8), ex_xx8);
    chk({tag, "_zz"}, 128'(zz8), ex_zz8);
    chk({tag, "_bp"}, 128'(bp8), ex_bp8);
  endtask

  task automatic run128(input logic [1:0] m, input logic s, input logic [127:0] a,
                        input logic [127:0] b, input string tag);
    int lat, cyc;
    lat = lat_of(m, 128);
    @(negedge clk);
    mode128 = m; swap128 = s; rx128 = a; ry128 = b; start128 = 1'b1;
    @(posedge clk); #1;
    start128 = 1'b0; rx128 = {4{$urandom}};
    model(m, s, a, b, 128, 128'h87, 0, ex_xx128, ex_zz128, ex_bp128, ex_zf128);
    cyc = 1;
    while (!done128 && cyc <= lat + 4) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(lat));
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
    chk({tag, "_zero_flag"}, 128'(zf128), 128'(ex_zf128));
`endif
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 128'(busy128), 128'(0));
    chk({tag, "_xx"}, xx128, ex_xx128);
    chk({tag, "_zz"}, zz128, ex_zz128);
    chk({tag, "_bp"}, bp128, ex_bp128);
  endtask

  initial begin
    logic [1:0] m;
    int lat, ac, dones;
    start8 = 0; swap8 = 0; abort8 = 0; mode8 = 0; rx8 = 0; ry8 = 0;
    start128 = 0; swap128 = 0; abort128 = 0; mode128 = 0; rx128 = 0; ry128 = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_xx8", 128'(xx8), 128'(0));
    chk("rst_zz8", 128'(zz8), 128'(0));
    chk("rst_bp8", 128'(bp8), 128'(0));
    chk("rst_busy8", 128'(busy8), 128'(0));
    chk("rst_done8", 128'(done8), 128'(0));
    chk("rst_xx128", xx128, 128'(0));
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
    chk("rst_zf8", 128'(zf8), 128'(0));
`endif
    @(negedge clk); rst = 1'b1;

    run8(2'b01, 1'b0, 8'h57, 8'h83, 1'b0, 0, "mul_only");
    chk("mul_only_c1", 128'(xx8), 128'hC1);
    run8(2'b00, 1'b0, 8'h57, 8'h83, 1'b0, 0, "chain");
    chk("chain_xx_c1", 128'(xx8), 128'h C1);
    chk("chain_zz_96", 128'(zz8), 128'h 96);
    chk("chain_bp_95", 128'(bp8), 128'h 95);
    run8(2'b00, 1'b1, 8'h57, 8'h83, 1'b0, 0, "chain_swap");
    chk("chain_swap_zz_42", 128'(zz8), 128'h 42);
    run8(2'b11, 1'b0, 8'hA5, 8'h5A, 1'b1, 0, "add_hold_start");
    chk("add_ff", 128'(zz8), 128'h FF);
    run8(2'b00, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 5, "abort_mul5");
    run8(2'b00, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 0, "after_abort");

    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom);
      lat = lat_of(m, 8);
      ac = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0;
      run8(m, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), ac, "rand8");
    end

    run8(2'b01, 1'b0, 8'h00, 8'h13, 1'b0, 0, "zero_mul");
    chk("zero_mul_xx", 128'(xx8), 128'(0));
    run8(2'b11, 1'b1, 8'h3C, 8'h3C, 1'b0, 0, "zero_add");
    run8(2'b10, 1'b0, 8'h02, 8'h00, 1'b0, 0, "sqr_x");
    chk("sqr_x_bp", 128'(bp8), 128'h04);

    // Reset asserted in the middle of a square.
    @(negedge clk);
    mode8 = 2'b10; rx8 = 8'($urandom); start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_xx", 128'(xx8), 128'(0));
    chk("mid_rst_zz", 128'(zz8), 128'(0));
    chk("mid_rst_bp", 128'(bp8), 128'(0));
    chk("mid_rst_busy", 128'(busy8), 128'(0));
    chk("mid_rst_done", 128'(done8), 128'(0));
    ex_xx8 = '0; ex_zz8 = '0; ex_bp8 = '0; ex_zf8 = 1'b0;
`ifdef ECC_GF2M_SEQ_ZERO_CHK_EN
    chk("mid_rst_zf", 128'(zf8), 128'(0));
`endif
    @(negedge clk); rst = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    chk("mid_rst_no_done", 128'(dones), 128'(0));
    run8(2'b00, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 0, "after_rst");

    run128(2'b01, 1'b0, 128'd1, {1'b1, 127'b0}, "w128_one");
    chk("w128_one_msb", xx128, {1'b1, 127'b0});
    run128(2'b01, 1'b0, 128'd2, {1'b1, 127'b0}, "w128_wrap");
    chk("w128_wrap_87", xx128, 128'h87);
    for (int i = 0; i < 3; i++)
      run128(2'($urandom), 1'($urandom), {4{$urandom}}, {4{$urandom}}, "rand128");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ecc_gf2m_seq.md
Name: ecc_gf2m_seq

Overview:
- Parametrised successor to the fixed 128-bit ECC core sequencer, for any binary-field width.
- Embeds its own bit-serial GF(2^WIDTH) multiplier, so it needs no external ALU.
- Runs one of four operation modes, with operand swap, a start/busy/done handshake and abort.
- Sits between the point-arithmetic controller and the coordinate register file; one instance per ladder lane.

Parameters:
- WIDTH, 128, field degree m; all operand and result buses are WIDTH bits.
- POLY, 128'h87, reduction polynomial without the x^WIDTH term (bit i = coefficient of x^i); low WIDTH bits used.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- mode  in  2  00=chain (mul, add, sqr), 01=mul only, 10=sqr only, 11=add only.
- swap  in  1  when 1, exchange rx and ry at capture.
- abort  in  1  synchronous cancel; return to IDLE.
- rx  in  WIDTH  operand X.
- ry  in  WIDTH  operand Y.
- xx_out  out  WIDTH  multiply result.
- zz_out  out  WIDTH  add result.
- bp_out  out  WIDTH  square result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=0): state=IDLE; xx_out, zz_out, bp_out, internal operands and accumulator = 0; busy=0; done=0. Reset mid-operation discards all work; no done pulse.
- Capture: in IDLE with start=1, operands latch on that edge. op_a=swap?ry:rx, op_b=swap?rx:ry. mode latches at the same time; later mode/swap/rx/ry changes are ignored.
- Next state after capture: MUL for mode 00/01, SQR for 10, ADD for 11.
- start while busy is ignored; no queueing.
- MUL: MSB-first bit-serial, WIDTH cycles; counter runs WIDTH-1 down to 0.
  - Per cycle: acc = xtime(acc) ^ (op_b[i] ? op_a : 0).
  - xtime(v) = (v<<1) truncated to WIDTH, then ^POLY if v[WIDTH-1] was 1.
  - acc cleared on MUL entry. On the last cycle: xx_out <= result.
  - Next: ADD for mode 00, DONE for mode 01.
- ADD: 1 cycle; zz_out <= operand ^ op_a.
  - Operand is xx_out result for mode 00, op_b for mode 11.
  - Next: SQR for mode 00, DONE for mode 11.
- SQR: same datapath with both multiplicands equal to the source, WIDTH cycles; bp_out <= result.
  - Source is zz_out result for mode 00, op_a for mode 10.
  - Next: DONE.
- DONE: done=1 for exactly one cycle, busy=1; next IDLE. A start in DONE is ignored.
- Outputs not written by the selected mode hold their previous values.
- Latency from capture edge to the cycle done is high: chain 2*WIDTH+2, mul-only WIDTH+1, sqr-only WIDTH+1, add-only 2.
- abort=1 in any busy state (MUL, ADD, SQR, DONE): next state IDLE, no done.
  - Outputs already written keep their values; a partial accumulator is never written out.
  - abort in IDLE has no effect; abort and start together in IDLE gives start priority.
- Bit-exact GF(2) arithmetic; no carries; results always fully reduced to WIDTH bits.
- Operands of 0 are legal and produce 0 products.

Optional Feature:
- Macro: ECC_GF2M_SEQ_ZERO_CHK_EN.
- Defined: adds output zero_flag (1 bit, reset 0). In the DONE cycle it is driven to 1 if the last written result of the selected mode is all-zero, else 0. It holds until the next DONE or reset. Used as a point-at-infinity indicator.
- Undefined: port absent; no extra logic.

Test Plan:
- WIDTH=8, POLY=8'h1B, mode=01, rx=8'h57, ry=8'h83 -> xx_out=8'hC1, done pulse exactly 9 cycles after capture, busy high for 9 cycles.
- WIDTH=8, POLY=8'h1B, mode=00, rx=8'h57, ry=8'h83, swap=0 -> xx_out=8'hC1, zz_out=8'h96, bp_out=8'h95, done 18 cycles after capture; same result with swap=1, except zz_out=8'hC1^8'h83=8'h42 and bp_out=square of 8'h42.
- WIDTH=8, mode=11, rx=8'hA5, ry=8'h5A -> zz_out=8'hFF after 2 cycles, xx_out/bp_out unchanged; start asserted while busy -> no second operation.
- WIDTH=8, mode=00, abort at cycle 5 of MUL -> IDLE next cycle, no done, all outputs keep their previous values; a new start then completes normally.
- rst=0 pulsed during SQR -> all outputs 0, busy=0, no done; with ECC_GF2M_SEQ_ZERO_CHK_EN, mode=01, rx=0, ry=8'h13 -> xx_out=0, zero_flag=1 at DONE.
- WIDTH=128, POLY=128'h87, mode=01, rx=1, ry=128'h8000...0 -> xx_out=128'h8000...0; then rx=2, ry=128'h8000...0 -> xx_out=128'h87.
